// File: rtl/lock_key_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lock_key_pkg
//  Description : Shared constants, state encoding and CRC-8 step for the
//                logic-locking key loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package lock_key_pkg;

    localparam int         KEY_W_DEFAULT = 92;
    localparam logic [7:0] SYNC_DEFAULT  = 8'hA5;
    localparam logic [7:0] CRC8_POLY     = 8'h07;

    // Key field layout on the locked core: X_1..X_88 then p1..p4
    localparam int X_BASE  = 0;
    localparam int X_COUNT = 88;
    localparam int P_BASE  = 88;
    localparam int P_COUNT = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_PAYLOAD = 3'd1;
    localparam state_t ST_CRC     = 3'd2;
    localparam state_t ST_DRAIN   = 3'd3;
    localparam state_t ST_COMMIT  = 3'd4;
    localparam state_t ST_LOCKOUT = 3'd5;

    // MSB-first CRC-8 over one byte, init handled by the caller
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lock_key_loader_crc8.sv
`default_nettype none
// ============================================================================
//  Module      : crc8_serial_update
//  Description : Combinational byte-wise CRC-8 (poly 0x07) update step.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc8_serial_update
    import lock_key_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    assign crc_out = crc8_byte(crc_in, data_in);

endmodule
`default_nettype wire

// File: rtl/lock_key_loader.sv
`default_nettype none
// ============================================================================
//  Module      : lock_key_loader
//  Description : Framed, CRC-checked byte stream to key bus for a locked core;
//                fail-safe clear on bad frames and lockout after repeats.
//  Revision    : 1.0 - initial release
// ============================================================================
module lock_key_loader
    import lock_key_pkg::*;
#(
    parameter int         KEY_W    = KEY_W_DEFAULT,
    parameter logic [7:0] SYNC     = SYNC_DEFAULT,
    parameter int         MAX_FAIL = 3
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             load_err,
    output logic             lockout,
    output logic             busy
);

    localparam int KEY_BYTES  = (KEY_W + 7) / 8;
    localparam int c_SHADOW_W = KEY_BYTES * 8;
    localparam int c_PAD_BITS = c_SHADOW_W - KEY_W;
    localparam int c_BCNT_W   = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam int c_FCNT_W   = $clog2(MAX_FAIL + 1);

    localparam logic [7:0]          c_PAD_MASK  = 8'(8'hFF << (8 - c_PAD_BITS));
    localparam logic [c_BCNT_W-1:0] c_LAST_BYTE = c_BCNT_W'(KEY_BYTES - 1);
    localparam logic [c_FCNT_W-1:0] c_MAX_FAIL  = c_FCNT_W'(MAX_FAIL);

    state_t                  r_state;
    logic [c_BCNT_W-1:0]     r_byte_cnt;
    logic [7:0]              r_crc;
    logic [c_SHADOW_W-1:0]   r_shadow;
    logic                    r_pad_err;
    logic [c_FCNT_W-1:0]     r_fail_cnt;
    logic [KEY_W-1:0]        r_key;
    logic                    r_key_valid;
    logic                    r_load_err;

    logic                    w_accept;
    logic [7:0]              w_crc_next;
    logic                    w_crc_ok;
    logic                    w_fail;
    state_t                  w_fail_dest;
    logic [c_FCNT_W-1:0]     w_fail_cnt_inc;
    logic                    w_fail_lock;

    crc8_serial_update u_crc (
        .crc_in  (r_crc),
        .data_in (in_data),
        .crc_out (w_crc_next)
    );

    assign in_ready = (r_state == ST_IDLE) || (r_state == ST_PAYLOAD) ||
                      (r_state == ST_CRC)  || (r_state == ST_DRAIN);
    assign w_accept = in_valid && in_ready;

    assign w_fail_cnt_inc = (r_fail_cnt >= c_MAX_FAIL) ? r_fail_cnt : r_fail_cnt + 1'b1;
    assign w_fail_lock    = (w_fail_cnt_inc >= c_MAX_FAIL);

    always_comb begin
        w_crc_ok    = in_last && (in_data == r_crc) && !r_pad_err;
        w_fail      = 1'b0;
        w_fail_dest = ST_IDLE;
        if (w_accept) begin
            if (r_state == ST_PAYLOAD && in_last) begin
                w_fail = 1'b1;
            end else if (r_state == ST_CRC && !w_crc_ok) begin
                w_fail      = 1'b1;
                w_fail_dest = in_last ? ST_IDLE : ST_DRAIN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_byte_cnt  <= '0;
            r_crc       <= 8'h00;
            r_shadow    <= '0;
            r_pad_err   <= 1'b0;
            r_fail_cnt  <= '0;
            r_key       <= '0;
            r_key_valid <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_load_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && in_data == SYNC && !in_last) begin
                        r_state    <= ST_PAYLOAD;
                        r_crc      <= 8'h00;
                        r_byte_cnt <= '0;
                        r_pad_err  <= 1'b0;
                    end
                end
                ST_PAYLOAD: begin
                    if (w_accept) begin
                        for (int k = 0; k < KEY_BYTES; k++) begin
                            if (r_byte_cnt == c_BCNT_W'(k)) begin
                                r_shadow[8*k +: 8] <= in_data;
                            end
                        end
                        r_crc      <= w_crc_next;
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                        if (r_byte_cnt == c_LAST_BYTE) begin
                            if ((in_data & c_PAD_MASK) != 8'h00) begin
                                r_pad_err <= 1'b1;
                            end
                            r_state <= ST_CRC;
                        end
                    end
                end
                ST_CRC: begin
                    if (w_accept && w_crc_ok) begin
                        r_state <= ST_COMMIT;
                    end
                end
                ST_DRAIN: begin
                    if (w_accept && in_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_COMMIT: begin
                    r_key       <= r_shadow[KEY_W-1:0];
                    r_key_valid <= 1'b1;
                    r_fail_cnt  <= '0;
                    r_state     <= ST_IDLE;
                end
                ST_LOCKOUT: begin
                    r_key       <= '0;
                    r_key_valid <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Rejection overrides any transition chosen above
            if (w_fail) begin
                r_load_err  <= 1'b1;
                r_key       <= '0;
                r_key_valid <= 1'b0;
                r_fail_cnt  <= w_fail_cnt_inc;
                r_state     <= w_fail_lock ? ST_LOCKOUT : w_fail_dest;
            end
        end
    end

    generate
        if (c_PAD_BITS > 0) begin : g_pad_sink
            logic w_unused_pad;
            assign w_unused_pad = ^r_shadow[c_SHADOW_W-1:KEY_W];
        end
    endgenerate

    assign key_out   = r_key;
    assign key_valid = r_key_valid;
    assign load_err  = r_load_err;
    assign lockout   = (r_state == ST_LOCKOUT);
    assign busy      = (r_state != ST_IDLE) && (r_state != ST_LOCKOUT);

endmodule
`default_nettype wire

// File: tb/tb_lock_key_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lock_key_loader
//  Description : Directed self-checking bench with a frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lock_key_loader;

    localparam int         KEY_W     = 92;
    localparam int         KEY_BYTES = 12;
    localparam logic [7:0] SYNC      = 8'hA5;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_data  = 8'h00;
    logic             in_last  = 1'b0;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic             load_err;
    logic             lockout;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;
    int gap_pct = 0;

    lock_key_loader #(.KEY_W(KEY_W), .SYNC(SYNC), .MAX_FAIL(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .key_out   (key_out),
        .key_valid (key_valid),
        .load_err  (load_err),
        .lockout   (lockout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Bit-serial polynomial division, init 0, MSB first
    function automatic logic [7:0] ref_crc(input logic [7:0] p[16], input int n);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ p[i][b];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    // ---------------- frame-level reference model ----------------
    typedef enum int {M_HUNT, M_FRAME, M_DRAIN, M_COMMIT, M_LOCKED} mphase_t;
    mphase_t          m_phase;
    logic [7:0]       m_buf[16];
    int               m_n;
    int               m_fails;
    logic [KEY_W-1:0] m_pending;
    logic [KEY_W-1:0] exp_key;
    logic             exp_valid;
    logic             exp_err;

    function automatic logic m_ready();
        return !(m_phase == M_LOCKED || m_phase == M_COMMIT);
    endfunction

    task automatic model_reset();
        m_phase = M_HUNT; m_n = 0; m_fails = 0;
        exp_key = '0; exp_valid = 1'b0; exp_err = 1'b0;
    endtask

    task automatic model_fail();
        exp_err = 1'b1; exp_key = '0; exp_valid = 1'b0;
        if (m_fails < 3) m_fails++;
        if (m_fails >= 3) m_phase = M_LOCKED;
    endtask

    task automatic model_step();
        logic acc;
        logic good;
        exp_err = 1'b0;
        acc = in_valid && m_ready();
        case (m_phase)
            M_COMMIT: begin
                exp_key = m_pending; exp_valid = 1'b1; m_fails = 0; m_phase = M_HUNT;
            end
            M_HUNT: if (acc && in_data == SYNC && !in_last) begin
                m_phase = M_FRAME; m_n = 0;
            end
            M_FRAME: if (acc) begin
                m_buf[m_n] = in_data;
                m_n++;
                if (m_n <= KEY_BYTES) begin
                    if (in_last) begin m_phase = M_HUNT; model_fail(); end
                end else begin
                    good = in_last && (ref_crc(m_buf, KEY_BYTES) == m_buf[KEY_BYTES]) &&
                           ((m_buf[KEY_BYTES-1] & 8'hF0) == 8'h00);
                    if (good) begin
                        m_pending = '0;
                        for (int k = 0; k < KEY_BYTES; k++)
                            for (int b = 0; b < 8; b++)
                                if (8*k + b < KEY_W) m_pending[8*k + b] = m_buf[k][b];
                        m_phase = M_COMMIT;
                    end else begin
                        m_phase = in_last ? M_HUNT : M_DRAIN;
                        model_fail();
                    end
                end
            end
            M_DRAIN: if (acc && in_last) m_phase = M_HUNT;
            default: ;
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            cmp("key_out",   128'(key_out),   128'(exp_key));
            cmp("key_valid", 128'(key_valid), 128'(exp_valid));
            cmp("load_err",  128'(load_err),  128'(exp_err));
            cmp("lockout",   128'(lockout),   128'(m_phase == M_LOCKED));
            cmp("busy",      128'(busy),      128'(m_phase == M_FRAME || m_phase == M_DRAIN || m_phase == M_COMMIT));
            if (rst_n) cmp("in_ready", 128'(in_ready), 128'(m_ready()));
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] pay[12];

    task automatic send_byte(input logic [7:0] d, input logic l, input logic expect_acc);
        logic acc;
        int   limit;
        acc   = 1'b0;
        limit = expect_acc ? 40 : 4;
        if (gap_pct != 0 && int'($urandom_range(99)) < gap_pct)
            repeat (int'($urandom_range(3, 1))) @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = l;
        for (int w = 0; w < limit && !acc; w++) begin
            acc = in_ready;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
        cmp("handshake", 128'(acc), 128'(expect_acc));
    endtask

    task automatic set_zero();
        for (int i = 0; i < 12; i++) pay[i] = 8'h00;
    endtask

    function automatic logic [7:0] pay_crc();
        logic [7:0] t[16];
        for (int i = 0; i < 16; i++) t[i] = (i < 12) ? pay[i] : 8'h00;
        return ref_crc(t, 12);
    endfunction

    task automatic send_frame(input logic [7:0] crc, input logic crc_last);
        send_byte(SYNC, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) send_byte(pay[i], 1'b0, 1'b1);
        send_byte(crc, crc_last, 1'b1);
    endtask

    task automatic good_zero_frame();
        set_zero();
        send_frame(pay_crc(), 1'b1);
        @(negedge clk);
    endtask

    logic [7:0]       chk[16];
    logic [KEY_W-1:0] nz_key;

    initial begin
        nz_key = {4'hF, 80'h0, 8'hFF};

        for (int i = 0; i < 16; i++) chk[i] = 8'h00;
        chk[0] = "1"; chk[1] = "2"; chk[2] = "3"; chk[3] = "4"; chk[4] = "5";
        chk[5] = "6"; chk[6] = "7"; chk[7] = "8"; chk[8] = "9";
        cmp("ref_crc_check_123456789", 128'(ref_crc(chk, 9)), 128'h F4);
        set_zero();
        cmp("ref_crc_zero_payload", 128'(pay_crc()), 128'h00);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cmp("reset_key_out", 128'(key_out), 128'h0);
        cmp("reset_key_valid", 128'(key_valid), 128'h0);
        cmp("reset_busy", 128'(busy), 128'h0);

        // Good all-zero load
        set_zero();
        send_frame(8'h00, 1'b1);
        cmp("commit_pending_busy", 128'(busy), 128'h1);
        @(negedge clk);
        cmp("zero_key_out", 128'(key_out), 128'h0);
        cmp("zero_key_valid", 128'(key_valid), 128'h1);

        // Good nonzero load, gap-free
        set_zero(); pay[0] = 8'hFF; pay[11] = 8'h0F;
        send_frame(pay_crc(), 1'b1);
        @(negedge clk);
        cmp("nz_key_out", 128'(key_out), 128'(nz_key));
        cmp("nz_key_valid", 128'(key_valid), 128'h1);

        // Noise in IDLE, then the same key with random gaps
        good_zero_frame();
        send_byte(8'h00, 1'b0, 1'b1);
        send_byte(8'h5A, 1'b0, 1'b1);
        send_byte(SYNC,  1'b1, 1'b1);
        cmp("noise_no_err", 128'(load_err), 128'h0);
        gap_pct = 40;
        set_zero(); pay[0] = 8'hFF; pay[11] = 8'h0F;
        send_frame(pay_crc(), 1'b1);
        gap_pct = 0;
        @(negedge clk);
        cmp("gap_key_out", 128'(key_out), 128'(nz_key));

        // CRC mismatch
        set_zero();
        send_frame(8'h01, 1'b1);
        cmp("crc_bad_err", 128'(load_err), 128'h1);
        cmp("crc_bad_key", 128'(key_out), 128'h0);
        cmp("crc_bad_valid", 128'(key_valid), 128'h0);

        // in_last on payload byte 5
        send_byte(SYNC, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) send_byte(8'h33, (i == 5), 1'b1);
        cmp("early_last_err", 128'(load_err), 128'h1);
        cmp("early_last_idle", 128'(busy), 128'h0);

        good_zero_frame();

        // CRC byte without in_last: drain to end of frame
        set_zero();
        send_frame(8'h00, 1'b0);
        cmp("drain_err", 128'(load_err), 128'h1);
        cmp("drain_busy", 128'(busy), 128'h1);
        send_byte(8'h11, 1'b0, 1'b1);
        send_byte(SYNC,  1'b0, 1'b1);
        send_byte(8'h22, 1'b1, 1'b1);
        cmp("drain_done_idle", 128'(busy), 128'h0);
        cmp("drain_done_no_err", 128'(load_err), 128'h0);

        // Pad violation with a correct CRC
        set_zero(); pay[11] = 8'h1F;
        send_frame(pay_crc(), 1'b1);
        cmp("pad_err", 128'(load_err), 128'h1);

        good_zero_frame();

        // Three consecutive bad frames
        set_zero();
        for (int f = 0; f < 3; f++) send_frame(8'h01, 1'b1);
        cmp("lockout_set", 128'(lockout), 128'h1);
        cmp("lockout_ready", 128'(in_ready), 128'h0);
        send_byte(SYNC, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        cmp("lockout_key_valid", 128'(key_valid), 128'h0);

        // Reset exits lockout
        #2 rst_n = 1'b0;
        #1 cmp("rst_lockout_clr", 128'(lockout), 128'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Commit a key, then reset mid-frame
        set_zero(); pay[0] = 8'hFF; pay[11] = 8'h0F;
        send_frame(pay_crc(), 1'b1);
        @(negedge clk);
        cmp("post_rst_key", 128'(key_out), 128'(nz_key));
        send_byte(SYNC, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'hC3, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        cmp("midrst_key_async", 128'(key_out), 128'h0);
        cmp("midrst_valid", 128'(key_valid), 128'h0);
        cmp("midrst_busy", 128'(busy), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        good_zero_frame();
        cmp("final_key_valid", 128'(key_valid), 128'h1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete, limit %0d ns", 500000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
